// File: rtl/prioritary_encoder.sv
// Keypad front-end: highest pressed key (0..9) -> registered BCD code D, valid flag and new-key strobe.
// Optional macro DEBOUNCE_EN inserts a 2-flop synchroniser and stability counter ahead of the encoder.
module prioritary_encoder
`ifdef DEBOUNCE_EN
  #(parameter int DEBOUNCE_CYCLES = 16)
`endif
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] keypad,
  input  logic       enablen,
  output logic [3:0] D,
  output logic       valid,
  output logic       key_strobe
);

  logic [9:0] pattern;
  logic [3:0] code;
  logic       hit;

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [9:0]    sync1, sync2, cand, accepted;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          changed, accept;

  // cnt counts clocks the synchronised pattern has matched cand, saturating at CNT_MAX.
  always_comb begin
    changed = (sync2 != cand);
    if (changed)
      cnt_nxt = CW'(1);
    else if (cnt == CNT_MAX)
      cnt_nxt = CNT_MAX;
    else
      cnt_nxt = cnt + CW'(1);
    accept = (cnt_nxt == CNT_MAX) && (changed || (cnt != CNT_MAX));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      cand     <= '0;
      cnt      <= CNT_MAX;
      accepted <= '0;
    end else begin
      sync1 <= keypad;
      sync2 <= sync1;
      cand  <= sync2;
      cnt   <= cnt_nxt;
      if (accept)
        accepted <= sync2;
    end
  end

  assign pattern = accepted;
`else
  assign pattern = keypad;
`endif

  // Later iterations overwrite earlier ones, so the highest set bit wins.
  always_comb begin
    code = 4'b1111;
    hit  = 1'b0;
    if (!enablen) begin
      for (int i = 0; i < 10; i++) begin
        if (pattern[i]) begin
          code = 4'(i);
          hit  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      D          <= 4'b1111;
      valid      <= 1'b0;
      key_strobe <= 1'b0;
    end else begin
      D          <= code;
      valid      <= hit;
      key_strobe <= hit && (!valid || (code != D));
    end
  end

endmodule

// File: tb/tb_prioritary_encoder.sv
// Self-checking bench for prioritary_encoder: directed scenarios plus randomized stimulus vs a reference model.
module tb_prioritary_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] keypad;
  logic       enablen;
  logic [3:0] D;
  logic       valid;
  logic       key_strobe;

  int checks   = 0;
  int failures = 0;

  // Reference model state: what D/valid/key_strobe should be after the latest edge.
  logic [3:0] m_d;
  logic       m_v;
  logic       m_s;

`ifdef DEBOUNCE_EN
  prioritary_encoder #(.DEBOUNCE_CYCLES(4)) dut (
`else
  prioritary_encoder dut (
`endif
    .clk(clk), .reset(reset), .keypad(keypad), .enablen(enablen),
    .D(D), .valid(valid), .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  // Highest pressed key index = floor(log2(keypad)).
  function automatic logic [3:0] ref_code(input logic [9:0] kp, input logic en_n);
    int v;
    if (en_n || kp == 10'd0) return 4'b1111;
    v = int'(kp);
    return 4'($clog2(v + 1) - 1);
  endfunction

  task automatic model_reset();
    m_d = 4'b1111;
    m_v = 1'b0;
    m_s = 1'b0;
  endtask

  // Advance one clock with current inputs and update the model; outputs sampled 1 time unit after the edge.
  task automatic tick();
    logic [3:0] nd;
    logic       nv;
    nd = ref_code(keypad, enablen);
    nv = !enablen && (keypad != 10'd0);
    @(posedge clk);
    #1;
    m_s = nv && (!m_v || nd != m_d);
    m_d = nd;
    m_v = nv;
  endtask

  task automatic test_reset();
    reset = 1'b1; keypad = 10'h3FF; enablen = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (D !== 4'hF || valid !== 1'b0 || key_strobe !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: D=%h valid=%b strobe=%b expected D=f valid=0 strobe=0", D, valid, key_strobe);
    end
    keypad = 10'd0;
    reset = 1'b0;
  endtask

  task automatic test_disabled_walk();
    enablen = 1'b1;
    for (int i = 0; i < 10; i++) begin
      keypad = 10'(1 << i);
      tick();
      checks++;
      if (D !== 4'hF || valid !== 1'b0 || key_strobe !== 1'b0) begin
        failures++;
        $display("FAIL disabled_walk[%0d]: D=%h valid=%b strobe=%b expected D=f valid=0 strobe=0", i, D, valid, key_strobe);
      end
    end
  endtask

  task automatic test_onehot_walk();
    int strobes;
    enablen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      keypad  = 10'(1 << i);
      strobes = 0;
      for (int c = 0; c < 5; c++) begin
        tick();
        strobes += int'(key_strobe);
        checks++;
        if (D !== 4'(i) || valid !== 1'b1 || key_strobe !== m_s) begin
          failures++;
          $display("FAIL onehot[%0d] cyc%0d: D=%h valid=%b strobe=%b expected D=%h valid=1 strobe=%b", i, c, D, valid, key_strobe, 4'(i), m_s);
        end
      end
      checks++;
      if (strobes != 1) begin
        failures++;
        $display("FAIL onehot_strobe_count[%0d]: got %0d expected 1", i, strobes);
      end
    end
  endtask

  task automatic test_multi_key();
    enablen = 1'b0;
    keypad  = 10'b00_1000_0100;
    tick();
    checks++;
    if (D !== 4'd7 || valid !== 1'b1) begin
      failures++;
      $display("FAIL multi_key: D=%h valid=%b expected D=7 valid=1", D, valid);
    end
    keypad = 10'd0;
    tick();
    checks++;
    if (D !== 4'hF || valid !== 1'b0 || key_strobe !== 1'b0) begin
      failures++;
      $display("FAIL multi_key_release: D=%h valid=%b strobe=%b expected D=f valid=0 strobe=0", D, valid, key_strobe);
    end
  endtask

  task automatic test_enable_toggle();
    logic [3:0] exp_d [6] = '{4'd5, 4'd5, 4'hF, 4'hF, 4'd5, 4'd5};
    logic       exp_s [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       en_seq[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    keypad = 10'(1 << 5);
    for (int c = 0; c < 6; c++) begin
      enablen = en_seq[c];
      tick();
      checks++;
      if (D !== exp_d[c] || valid !== (exp_d[c] != 4'hF) || key_strobe !== exp_s[c]) begin
        failures++;
        $display("FAIL enable_toggle cyc%0d: D=%h valid=%b strobe=%b expected D=%h strobe=%b", c, D, valid, key_strobe, exp_d[c], exp_s[c]);
      end
    end
    keypad = 10'd0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 4))
        0: keypad = 10'd0;
        1: keypad = 10'(1 << $urandom_range(0, 9));
        2: keypad = 10'($urandom);
        default: ; // hold the previous pattern to exercise held keys
      endcase
      enablen = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (D !== m_d || valid !== m_v || key_strobe !== m_s) begin
        failures++;
        $display("FAIL random cyc%0d kp=%b en_n=%b: D=%h valid=%b strobe=%b expected D=%h valid=%b strobe=%b",
                 c, keypad, enablen, D, valid, key_strobe, m_d, m_v, m_s);
      end
      checks++;
      if (D > 4'd9 && D != 4'hF) begin
        failures++;
        $display("FAIL random_code_range cyc%0d: D=%h expected 0..9 or f", c, D);
      end
    end
  endtask

  task automatic test_async_reset();
    enablen = 1'b0;
    keypad  = 10'h200;
    tick();
    tick();
    checks++;
    if (D !== 4'd9 || valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: D=%h valid=%b expected D=9 valid=1", D, valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (D !== 4'hF || valid !== 1'b0 || key_strobe !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: D=%h valid=%b strobe=%b expected D=f valid=0 strobe=0", D, valid, key_strobe);
    end
    @(posedge clk);
    #1;
    checks++;
    if (D !== 4'hF || valid !== 1'b0 || key_strobe !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: D=%h valid=%b strobe=%b expected D=f valid=0 strobe=0", D, valid, key_strobe);
    end
    #2 reset = 1'b0;
    model_reset();
    tick();
    checks++;
    if (D !== 4'd9 || valid !== 1'b1 || key_strobe !== 1'b1) begin
      failures++;
      $display("FAIL post_reset: D=%h valid=%b strobe=%b expected D=9 valid=1 strobe=1", D, valid, key_strobe);
    end
  endtask

`ifdef DEBOUNCE_EN
  task automatic test_debounce();
    enablen = 1'b0;
    keypad  = 10'(1 << 3);
    repeat (2) @(posedge clk);
    #1 keypad = 10'd0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (D !== 4'hF || valid !== 1'b0) begin
        failures++;
        $display("FAIL debounce_glitch cyc%0d: D=%h valid=%b expected D=f valid=0", c, D, valid);
      end
    end
    keypad = 10'(1 << 3);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (D !== ((c >= 7) ? 4'd3 : 4'hF)) begin
        failures++;
        $display("FAIL debounce_hold edge%0d: D=%h expected %h", c, D, (c >= 7) ? 4'd3 : 4'hF);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; keypad = 10'd0; enablen = 1'b1;
    #2;
    test_reset();
`ifdef DEBOUNCE_EN
    test_debounce();
`else
    test_disabled_walk();
    test_onehot_walk();
    test_multi_key();
    test_enable_toggle();
    test_random();
    test_async_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
